// File: rtl/lc4_pkg.sv
// ----------------------------------------------------------------------------
// lc4_pkg
//   Shared definitions for the LC4 instruction fetch slice.
//   - INSN_W / ADDR_W : instruction word and fetch address widths
//   - fetch_state_e   : fetch FSM state encoding (IDLE / REQ / DROP)
//   - fq_entry_t      : prefetch queue entry {insn, pc}
//   - pc_next()       : sequential fetch address, wraps FFFF -> 0000
// ----------------------------------------------------------------------------
package lc4_pkg;

    localparam int INSN_W = 20;
    localparam int ADDR_W = 16;

    // IDLE: no request on the bus
    // REQ : request outstanding, its data will be queued
    // DROP: request outstanding, but a redirect made its data stale
    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSN_W-1:0] insn;
        logic [ADDR_W-1:0] pc;
    } fq_entry_t;

    function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/lc4_fetch_queue.sv
// ----------------------------------------------------------------------------
// lc4_fetch_queue
//   Synchronous FIFO holding fetched {insn, pc} entries.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     push, push_data  write one entry (ignored when full or flushing)
//     pop              drop the head entry (ignored when empty or flushing)
//     flush            empty the queue this cycle; wins over push and pop
//     count            current occupancy, 0..DEPTH
//     head             head entry, all-zero when the queue is empty
//   DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module lc4_fetch_queue
    import lc4_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  fq_entry_t              push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output fq_entry_t              head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             empty;
    logic             full;
    logic             push_en;
    logic             pop_en;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign push_en = push & ~flush & ~full;
    assign pop_en  = pop & ~flush & ~empty;

    // NOTE: the storage array has no reset; an entry is only ever read after
    // it has been written, and head is forced to zero while the queue is empty.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            // A simultaneous push and pop leaves occupancy unchanged.
            case ({push_en, pop_en})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign count = cnt;
    assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/lc4_fetch.sv
// ----------------------------------------------------------------------------
// lc4_fetch
//   LC4 instruction fetch unit: issues one instruction-memory read at a time,
//   buffers returned words in a prefetch queue and presents the queue head to
//   the decoder. A redirect flushes the queue and restarts fetching at
//   redirect_pc; a read already on the bus is completed and its data dropped.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     imem_req, imem_addr        read request and its address (held until ack)
//     imem_ack, imem_rdata       request accepted, read data valid same cycle
//     redirect_valid/_pc         control transfer, highest priority
//     insn_valid, insn, insn_pc  registered queue head to the decoder
//     insn_ready                 decoder consumes the head this cycle
// ----------------------------------------------------------------------------
module lc4_fetch
    import lc4_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          QDEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INSN_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              insn_valid,
    output logic [INSN_W-1:0] insn,
    output logic [ADDR_W-1:0] insn_pc,
    input  logic              insn_ready
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] fetch_pc_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    logic              push;
    logic              pop;
    fq_entry_t         push_entry;
    fq_entry_t         head;
    logic [CNT_W-1:0]  q_count;
    logic [CNT_W-1:0]  count_after;

    // A redirect cancels the decoder's consume in the same cycle.
    assign pop        = insn_valid & insn_ready & ~redirect_valid;
    assign push_entry = '{insn: imem_rdata, pc: addr_q};

    // NOTE: every signal written here gets a default first so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        addr_d      = addr_q;
        push        = 1'b0;
        // Occupancy after a push this cycle; only consulted when pushing.
        count_after = q_count + CNT_W'(1) - CNT_W'(pop);

        unique case (state_q)
            FS_IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                end else if (q_count < CNT_W'(QDEPTH)) begin
                    state_d = FS_REQ;
                    addr_d  = fetch_pc_q;
                end
            end

            FS_REQ: begin
                if (redirect_valid) begin
                    // The acked word (if any) belongs to the old stream.
                    fetch_pc_d = redirect_pc;
                    state_d    = imem_ack ? FS_IDLE : FS_DROP;
                end else if (imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = pc_next(fetch_pc_q);
                    // Chain straight into the next request when the queue
                    // still has room, so a ready decoder sees one insn/cycle.
                    if (count_after < CNT_W'(QDEPTH)) begin
                        state_d = FS_REQ;
                        addr_d  = pc_next(fetch_pc_q);
                    end else begin
                        state_d = FS_IDLE;
                    end
                end
            end

            FS_DROP: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                end
                if (imem_ack) begin
                    state_d = FS_IDLE;
                end
            end

            default: begin
                state_d = FS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FS_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    lc4_fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (q_count),
        .head      (head)
    );

    // The request address is a register, so it stays stable across REQ/DROP
    // even when a redirect moves fetch_pc.
    assign imem_req   = (state_q != FS_IDLE);
    assign imem_addr  = addr_q;

    assign insn_valid = (q_count != '0);
    assign insn       = head.insn;
    assign insn_pc    = head.pc;

endmodule

// File: tb/tb_lc4_fetch.sv
`timescale 1ns/1ps
module tb_lc4_fetch;
    import lc4_pkg::*;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int          QDEPTH   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [19:0] imem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        insn_valid;
    logic [19:0] insn;
    logic [15:0] insn_pc;
    logic        insn_ready;

    always #5 clk = ~clk;

    lc4_fetch #(
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .insn_valid     (insn_valid),
        .insn           (insn),
        .insn_pc        (insn_pc),
        .insn_ready     (insn_ready)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [19:0] mem_word(input logic [15:0] a);
        return {a[3:0] ^ a[15:12] ^ 4'h9, a ^ 16'h5AC3};
    endfunction

    // ---------------- reference model / scoreboard ----------------
    // The decoder must see the instruction stream starting at the last
    // reset/redirect target, one address after another (16-bit wrap).
    logic [15:0] sb_q[$];
    logic [15:0] model_next;

    function automatic void sb_restart(input logic [15:0] pc);
        sb_q.delete();
        model_next = pc;
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back(model_next);
            model_next = model_next + 16'd1;
        end
    endfunction

    // ---------------- instruction memory responder ----------------
    int lat_mode = 0;   // 0: ack at once, 1: random 0..3, 2: addr 0003 waits 3, 3: always 2
    int wait_cnt = 0;
    int cur_lat  = 0;
    bit have_lat = 1'b0;

    function automatic int pick_lat(input logic [15:0] a);
        case (lat_mode)
            1:       return int'($urandom_range(0, 3));
            2:       return (a == 16'h0003) ? 3 : 0;
            3:       return 2;
            default: return 0;
        endcase
    endfunction

    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (imem_ack) begin
                have_lat = 1'b0;
                wait_cnt = 0;
            end
            imem_ack   = 1'b0;
            imem_rdata = '0;
            if (!rst_n) begin
                have_lat = 1'b0;
                wait_cnt = 0;
            end else if (imem_req) begin
                if (!have_lat) begin
                    cur_lat  = pick_lat(imem_addr);
                    have_lat = 1'b1;
                    wait_cnt = 0;
                end
                if (wait_cnt >= cur_lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int          ack_cnt  = 0;
    int          pop_cnt  = 0;
    bit          prev_redirect = 1'b0;
    bit          prev_stall    = 1'b0;
    bit          prev_pending  = 1'b0;
    logic [35:0] saved_head;
    logic [15:0] saved_addr;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_redirect = 1'b0;
                prev_stall    = 1'b0;
                prev_pending  = 1'b0;
            end else begin
                if (prev_redirect) check("flush_empty", insn_valid, 1'b0);
                if (prev_stall) begin
                    check("stall_valid", insn_valid, 1'b1);
                    check("stall_head", {insn, insn_pc}, saved_head);
                end
                if (prev_pending) begin
                    check("req_held", imem_req, 1'b1);
                    check("req_addr_held", imem_addr, saved_addr);
                end
                if (imem_req && imem_ack) ack_cnt++;
                if (!redirect_valid && insn_valid && insn_ready) begin
                    logic [15:0] exp_pc;
                    if (sb_q.size() == 0) begin
                        sb_q.push_back(model_next);
                        model_next = model_next + 16'd1;
                    end
                    exp_pc = sb_q.pop_front();
                    sb_q.push_back(model_next);
                    model_next = model_next + 16'd1;
                    check("pop_pc", insn_pc, exp_pc);
                    check("pop_insn", insn, mem_word(exp_pc));
                    pop_cnt++;
                end
                prev_redirect = redirect_valid;
                prev_stall    = insn_valid && !insn_ready && !redirect_valid;
                saved_head    = {insn, insn_pc};
                prev_pending  = imem_req && !imem_ack;
                saved_addr    = imem_addr;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic timeout(input string name);
        failures++;
        checks++;
        $display("FAIL %s timeout waiting for DUT (t=%0t)", name, $time);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          found;
        logic [15:0] seen [3];
        int          n;
        int          rand_pops;

        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        insn_ready     = 1'b1;
        lat_mode       = 0;
        sb_restart(RESET_PC);

        // ---- reset state ----
        tick();
        tick();
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_insn_valid", insn_valid, 1'b0);
        check("rst_insn", insn, 20'h0);
        check("rst_insn_pc", insn_pc, 16'h0);

        // ---- back-to-back fetch with immediate ack ----
        rst_n = 1'b1;
        @(negedge clk);
        check("no_req_before_edge", imem_req, 1'b0);
        @(negedge clk);
        check("first_req", imem_req, 1'b1);
        check("first_req_addr", imem_addr, RESET_PC);
        @(negedge clk);
        check("seq0_valid", insn_valid, 1'b1);
        check("seq0_pc", insn_pc, 16'h0000);
        @(negedge clk);
        check("seq1_valid", insn_valid, 1'b1);
        check("seq1_pc", insn_pc, 16'h0001);
        @(negedge clk);
        check("seq2_valid", insn_valid, 1'b1);
        check("seq2_pc", insn_pc, 16'h0002);

        // ---- stalled decoder fills the queue ----
        tick();
        rst_n      = 1'b0;
        insn_ready = 1'b0;
        sb_restart(RESET_PC);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        ack_cnt = 0;
        repeat (11) @(negedge clk);
        check("stall_req_count", ack_cnt, 4);
        check("stall_req_off", imem_req, 1'b0);
        check("stall_head_valid", insn_valid, 1'b1);
        check("stall_head_pc", insn_pc, RESET_PC);
        check("stall_head_insn", insn, mem_word(RESET_PC));

        // ---- redirect while a slow request is outstanding ----
        tick();
        rst_n      = 1'b0;
        insn_ready = 1'b1;
        lat_mode   = 2;
        sb_restart(RESET_PC);
        tick();
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (imem_req && !imem_ack && imem_addr == 16'h0003) found = 1'b1;
        end
        if (!found) timeout("drop_wait_req3");
        redirect_valid = 1'b1;
        redirect_pc    = 16'h8200;
        sb_restart(16'h8200);
        tick();
        redirect_valid = 1'b0;
        check("drop_keeps_addr", imem_addr, 16'h0003);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (imem_req && imem_addr != 16'h0003) found = 1'b1;
        end
        if (!found) timeout("drop_wait_newreq");
        check("drop_next_addr", imem_addr, 16'h8200);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (insn_valid) found = 1'b1;
        end
        if (!found) timeout("drop_wait_insn");
        check("drop_first_pc", insn_pc, 16'h8200);

        // ---- redirect near the top of the address space ----
        tick();
        lat_mode       = 0;
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFE;
        sb_restart(16'hFFFE);
        tick();
        redirect_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 30 && n < 3; i++) begin
            @(negedge clk);
            if (insn_valid && insn_ready) begin
                seen[n] = insn_pc;
                n++;
            end
        end
        if (n < 3) timeout("wrap_wait");
        else begin
            check("wrap_pc0", seen[0], 16'hFFFE);
            check("wrap_pc1", seen[1], 16'hFFFF);
            check("wrap_pc2", seen[2], 16'h0000);
        end

        // ---- redirect + ack + pop in one cycle with a loaded queue ----
        tick();
        rst_n      = 1'b0;
        insn_ready = 1'b0;
        lat_mode   = 3;
        sb_restart(RESET_PC);
        tick();
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (imem_req && imem_ack && imem_addr == RESET_PC + 16'd3) found = 1'b1;
        end
        if (!found) timeout("coll_wait_ack");
        redirect_valid = 1'b1;
        redirect_pc    = 16'h1234;
        insn_ready     = 1'b1;
        sb_restart(16'h1234);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("coll_empty", insn_valid, 1'b0);
        check("coll_idle", imem_req, 1'b0);
        tick();
        #1;
        check("coll_req", imem_req, 1'b1);
        check("coll_req_addr", imem_addr, 16'h1234);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (insn_valid) found = 1'b1;
        end
        if (!found) timeout("coll_wait_insn");
        check("coll_first_pc", insn_pc, 16'h1234);

        // ---- asynchronous reset mid-request ----
        insn_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (imem_req && !imem_ack && insn_valid) found = 1'b1;
        end
        if (!found) timeout("areset_wait");
        #1;
        rst_n = 1'b0;
        #1;
        check("areset_req", imem_req, 1'b0);
        check("areset_valid", insn_valid, 1'b0);
        sb_restart(RESET_PC);
        tick();
        tick();
        rst_n = 1'b1;

        // ---- randomized traffic ----
        lat_mode  = 1;
        rand_pops = pop_cnt;
        for (int i = 0; i < 3000; i++) begin
            tick();
            insn_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 39) == 0) begin
                logic [15:0] tgt;
                tgt = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                                  : 16'($urandom);
                redirect_valid = 1'b1;
                redirect_pc    = tgt;
                sb_restart(tgt);
            end else begin
                redirect_valid = 1'b0;
            end
        end
        tick();
        redirect_valid = 1'b0;
        insn_ready     = 1'b1;
        repeat (20) tick();
        rand_pops = pop_cnt - rand_pops;
        check("rand_progress", (rand_pops > 500) ? 1'b1 : 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
